// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encoding, special byte values and event-entry layout
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      EXT,
      BRK,
      EXTBRK,
      SKIP
   } state_t;

   localparam logic [7:0] B_E0 = 8'hE0;
   localparam logic [7:0] B_F0 = 8'hF0;
   localparam logic [7:0] B_E1 = 8'hE1;
   localparam logic [7:0] B_AA = 8'hAA;
   localparam logic [7:0] B_FA = 8'hFA;
   localparam logic [7:0] B_FE = 8'hFE;
   localparam logic [7:0] B_00 = 8'h00;
   localparam logic [7:0] B_FF = 8'hFF;

   localparam logic [7:0] K_LSHIFT = 8'h12;
   localparam logic [7:0] K_RSHIFT = 8'h59;
   localparam logic [7:0] K_CTRL   = 8'h14;
   localparam logic [7:0] K_CAPS   = 8'h58;

   // Pause is E1 followed by seven more bytes that carry no key events
   localparam logic [2:0] SKIP_LEN = 3'd7;

   localparam int F_CODE  = 0;
   localparam int F_BRK   = 8;
   localparam int F_EXT   = 9;
   localparam int F_ASCII = 10;
   localparam int ENT_W   = 18;

   function automatic logic is_err(input logic [7:0] b);
      return b == B_00 || b == B_FF;
   endfunction

   // Bytes that are keyboard status/acks rather than key codes
   function automatic logic is_drop(input logic [7:0] b);
      return is_err(b) || b == B_AA || b == B_FA || b == B_FE;
   endfunction

   function automatic logic is_prefix(input logic [7:0] b);
      return b == B_E0 || b == B_F0 || b == B_E1;
   endfunction

endpackage

// File: rtl/ps2_set2_to_ascii.sv
// ps2_set2_to_ascii: combinational Set-2 scancode to ASCII lookup
module ps2_set2_to_ascii (
   input  logic [7:0] code,
   input  logic       ext,
   input  logic       shift,
   input  logic       caps,
   output logic [7:0] ascii
);

   logic       letter;
   logic       up;
   logic [7:0] lo;
   logic [7:0] hi;

   always_comb begin
      letter = 1'b0;
      lo     = 8'h00;
      hi     = 8'h00;
      case (code)
         8'h1C: {letter, lo, hi} = {1'b1, "a", "A"};
         8'h32: {letter, lo, hi} = {1'b1, "b", "B"};
         8'h21: {letter, lo, hi} = {1'b1, "c", "C"};
         8'h23: {letter, lo, hi} = {1'b1, "d", "D"};
         8'h24: {letter, lo, hi} = {1'b1, "e", "E"};
         8'h2B: {letter, lo, hi} = {1'b1, "f", "F"};
         8'h34: {letter, lo, hi} = {1'b1, "g", "G"};
         8'h33: {letter, lo, hi} = {1'b1, "h", "H"};
         8'h43: {letter, lo, hi} = {1'b1, "i", "I"};
         8'h3B: {letter, lo, hi} = {1'b1, "j", "J"};
         8'h42: {letter, lo, hi} = {1'b1, "k", "K"};
         8'h4B: {letter, lo, hi} = {1'b1, "l", "L"};
         8'h3A: {letter, lo, hi} = {1'b1, "m", "M"};
         8'h31: {letter, lo, hi} = {1'b1, "n", "N"};
         8'h44: {letter, lo, hi} = {1'b1, "o", "O"};
         8'h4D: {letter, lo, hi} = {1'b1, "p", "P"};
         8'h15: {letter, lo, hi} = {1'b1, "q", "Q"};
         8'h2D: {letter, lo, hi} = {1'b1, "r", "R"};
         8'h1B: {letter, lo, hi} = {1'b1, "s", "S"};
         8'h2C: {letter, lo, hi} = {1'b1, "t", "T"};
         8'h3C: {letter, lo, hi} = {1'b1, "u", "U"};
         8'h2A: {letter, lo, hi} = {1'b1, "v", "V"};
         8'h1D: {letter, lo, hi} = {1'b1, "w", "W"};
         8'h22: {letter, lo, hi} = {1'b1, "x", "X"};
         8'h35: {letter, lo, hi} = {1'b1, "y", "Y"};
         8'h1A: {letter, lo, hi} = {1'b1, "z", "Z"};
         8'h16: {letter, lo, hi} = {1'b0, "1", "!"};
         8'h1E: {letter, lo, hi} = {1'b0, "2", "@"};
         8'h26: {letter, lo, hi} = {1'b0, "3", "#"};
         8'h25: {letter, lo, hi} = {1'b0, "4", "$"};
         8'h2E: {letter, lo, hi} = {1'b0, "5", "%"};
         8'h36: {letter, lo, hi} = {1'b0, "6", "^"};
         8'h3D: {letter, lo, hi} = {1'b0, "7", "&"};
         8'h3E: {letter, lo, hi} = {1'b0, "8", "*"};
         8'h46: {letter, lo, hi} = {1'b0, "9", "("};
         8'h45: {letter, lo, hi} = {1'b0, "0", ")"};
         8'h0E: {letter, lo, hi} = {1'b0, 8'h60, "~"};
         8'h4E: {letter, lo, hi} = {1'b0, "-", "_"};
         8'h55: {letter, lo, hi} = {1'b0, "=", "+"};
         8'h54: {letter, lo, hi} = {1'b0, "[", "{"};
         8'h5B: {letter, lo, hi} = {1'b0, "]", "}"};
         8'h5D: {letter, lo, hi} = {1'b0, 8'h5C, "|"};
         8'h4C: {letter, lo, hi} = {1'b0, ";", ":"};
         8'h52: {letter, lo, hi} = {1'b0, "'", 8'h22};
         8'h41: {letter, lo, hi} = {1'b0, ",", "<"};
         8'h49: {letter, lo, hi} = {1'b0, ".", ">"};
         8'h4A: {letter, lo, hi} = {1'b0, "/", "?"};
         8'h29: {letter, lo, hi} = {1'b0, 8'h20, 8'h20};
         8'h5A: {letter, lo, hi} = {1'b0, 8'h0D, 8'h0D};
         8'h66: {letter, lo, hi} = {1'b0, 8'h08, 8'h08};
         default: {letter, lo, hi} = {1'b0, 8'h00, 8'h00};
      endcase
   end

   always_comb begin
      up    = letter ? shift ^ caps : shift;
      ascii = ext ? (code == 8'h5A ? 8'h0D : code == 8'h4A ? 8'h2F : 8'h00)
                  : (up ? hi : lo);
   end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: Set-2 prefix stripping, modifier tracking and event FIFO
module ps2_scancode_decoder
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int AW         = $clog2(FIFO_DEPTH)
) (
   input  logic       clk_50,
   input  logic       areset,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_code,
   output logic       out_ext,
   output logic       out_break,
   output logic [7:0] out_ascii,
   output logic       shift_st,
   output logic       ctrl_st,
   output logic       caps_st,
   output logic       ovf
);

   localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

   logic             rx_valid_q;
   logic             accept;
   state_t           state;
   state_t           state_nx;
   logic [2:0]       skip_cnt;
   logic [2:0]       skip_nx;
   logic             emit;
   logic             emit_ext;
   logic             emit_brk;
   logic             caps_held;
   logic [7:0]       ascii_lu;
   logic [ENT_W-1:0] ent;
   logic [ENT_W-1:0] rd_data;
   logic [ENT_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             full;
   logic             pop;
   logic             push;

   assign accept = rx_valid && !rx_valid_q;

   // Edge detector on the level-style receiver valid
   always_ff @(posedge clk_50 or posedge areset)
      if (areset) rx_valid_q <= 1'b0;
      else rx_valid_q <= rx_valid;

   // Prefix FSM state and Pause skip counter
   always_ff @(posedge clk_50 or posedge areset)
      if (areset) begin
         state    <= IDLE;
         skip_cnt <= 3'd0;
      end else begin
         state    <= state_nx;
         skip_cnt <= skip_nx;
      end

   // Next state on each accepted byte
   always_comb begin
      state_nx = state;
      skip_nx  = skip_cnt;
      if (accept)
         case (state)
            IDLE: begin
               state_nx = rx_data == B_E0 ? EXT : rx_data == B_F0 ? BRK : rx_data == B_E1 ? SKIP : IDLE;
               skip_nx  = rx_data == B_E1 ? SKIP_LEN : skip_cnt;
            end
            EXT: state_nx = is_err(rx_data) ? IDLE : rx_data == B_F0 ? EXTBRK : rx_data == B_E0 ? EXT : IDLE;
            SKIP: begin
               state_nx = (is_err(rx_data) || skip_cnt == 3'd1) ? IDLE : SKIP;
               skip_nx  = skip_cnt - 3'd1;
            end
            default: state_nx = IDLE;
         endcase
   end

   // Event emission and its flags, decided from the current prefix state
   always_comb begin
      emit_ext = state == EXT || state == EXTBRK;
      emit_brk = state == BRK || state == EXTBRK;
      emit     = accept && (state == IDLE ? !is_drop(rx_data) && !is_prefix(rx_data)
                          : state == EXT  ? !is_err(rx_data) && rx_data != B_F0 && rx_data != B_E0
                          : state == SKIP ? 1'b0
                          : !is_err(rx_data));
   end

   ps2_set2_to_ascii u_ascii (
      .code  (rx_data),
      .ext   (emit_ext),
      .shift (shift_st),
      .caps  (caps_st),
      .ascii (ascii_lu)
   );

   // Modifier tracking; caps_held blocks typematic repeats from re-toggling
   always_ff @(posedge clk_50 or posedge areset)
      if (areset) begin
         shift_st  <= 1'b0;
         ctrl_st   <= 1'b0;
         caps_st   <= 1'b0;
         caps_held <= 1'b0;
      end else if (emit) begin
         if (!emit_ext && (rx_data == K_LSHIFT || rx_data == K_RSHIFT)) shift_st <= !emit_brk;
         if (rx_data == K_CTRL) ctrl_st <= !emit_brk;
         if (!emit_ext && rx_data == K_CAPS) begin
            caps_held <= !emit_brk;
            if (!emit_brk && !caps_held) caps_st <= !caps_st;
         end
      end

   assign ent  = {emit_brk ? 8'h00 : ascii_lu, emit_ext, emit_brk, rx_data};
   assign full = count == FULL;
   assign pop  = out_valid && out_ready;
   assign push = emit && (!full || pop);

   // Event storage; written only, so no reset needed
   always_ff @(posedge clk_50)
      if (push) mem[wr_ptr] <= ent;

   // FIFO pointers, occupancy and overflow pulse
   always_ff @(posedge clk_50 or posedge areset)
      if (areset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
         ovf   <= emit && full && !pop;
      end

   assign out_valid = count != '0;
   assign rd_data   = out_valid ? mem[rd_ptr] : '0;
   assign out_code  = rd_data[F_CODE +: 8];
   assign out_break = rd_data[F_BRK];
   assign out_ext   = rd_data[F_EXT];
   assign out_ascii = rd_data[F_ASCII +: 8];

endmodule
